// File: rtl/game_tracker_pkg.sv
// Shared encodings and limits for the per-race measurement stage.
package game_tracker_pkg;

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_INGAME    = 2'd2,
    ST_FINISH    = 2'd3
  } ctrl_state_t;

  typedef enum logic [2:0] {
    T_IDLE,
    T_RUN,
    T_CALC_WPM,
    T_CALC_ACC,
    T_DONE
  } trk_state_t;

  localparam int unsigned DEF_TICKS_PER_SEC = 10;
  localparam int unsigned TIME_MIN  = 15;
  localparam int unsigned TIME_MAX  = 90;
  localparam int unsigned WORDS_MIN = 25;
  localparam int unsigned WORDS_MAX = 100;
  localparam int unsigned WPM_MAX   = 999;
  localparam int unsigned DIV_W     = 16;

endpackage

// File: rtl/game_tracker_seq_divider.sv
// 16/16 unsigned restoring divider: one load cycle, then one quotient bit per tick.
module seq_divider
  import game_tracker_pkg::*;
(
  input  logic             clk_div,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             busy,
  output logic             done
);

  logic [DIV_W-1:0] q_reg, r_reg, d_reg;
  logic [4:0]       cnt;
  logic             div_zero;
  logic [DIV_W:0]   shifted;
  logic             fits;

  always_comb begin
    shifted = {r_reg, q_reg[DIV_W-1]};
    fits    = (shifted >= {1'b0, d_reg});
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      q_reg    <= '0;
      r_reg    <= '0;
      d_reg    <= '0;
      cnt      <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      q_reg    <= dividend;
      r_reg    <= '0;
      d_reg    <= divisor;
      div_zero <= (divisor == '0);
      cnt      <= 5'd16;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (busy) begin
      if (fits) begin
        r_reg <= DIV_W'(shifted - {1'b0, d_reg});
        q_reg <= {q_reg[DIV_W-2:0], 1'b1};
      end else begin
        r_reg <= shifted[DIV_W-1:0];
        q_reg <= {q_reg[DIV_W-2:0], 1'b0};
      end
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient  = div_zero ? '0 : q_reg;
  assign remainder = div_zero ? '0 : r_reg;

endmodule

// File: rtl/game_tracker.sv
// Per-race timing/word/keystroke counters and post-race WPM/accuracy computation.
module game_tracker
  import game_tracker_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int unsigned CNT_W         = 10
) (
  input  logic       clk_div,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       mode,
  input  logic [6:0] value,
  input  logic       word_done,
  input  logic       char_ok,
  input  logic       char_err,
  output logic       finish,
  output logic [6:0] remaining,
  output logic [6:0] elapsed_s,
  output logic [6:0] words,
  output logic [9:0] wpm,
  output logic [6:0] accuracy,
  output logic       result_valid
);

  localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_t ctrl;
  trk_state_t  cur, nxt;

  logic [11:0]      ticks, ticks_n;
  logic [SUB_W-1:0] sub, sub_n;
  logic [6:0]       elapsed_n, words_n, target, base_n, rem_n;
  logic             mode_q;
  logic [CNT_W-1:0] ok_cnt, err_cnt, ok_n, err_n;
  logic             finish_n, counting, idle_hold;
  logic [15:0]      wpm_num, acc_num, acc_den;
  logic             div_start, div_busy, div_done;
  logic [15:0]      div_a, div_b, div_q;

  assign ctrl = ctrl_state_t'(state);

  // Next counter values; the finish test and the WPM operands both use these so
  // the first division can launch on the same tick the race ends.
  always_comb begin
    ticks_n   = (ticks == 12'hFFF) ? ticks : ticks + 12'd1;
    sub_n     = (sub == SUB_W'(TICKS_PER_SEC - 1)) ? '0 : sub + SUB_W'(1);
    elapsed_n = ((sub == SUB_W'(TICKS_PER_SEC - 1)) && (elapsed_s != 7'h7F))
                ? elapsed_s + 7'd1 : elapsed_s;
    words_n   = (word_done && (words != 7'h7F)) ? words + 7'd1 : words;
    ok_n      = (char_ok && (ok_cnt != CNT_MAX)) ? ok_cnt + 1'b1 : ok_cnt;
    err_n     = (char_err && (err_cnt != CNT_MAX)) ? err_cnt + 1'b1 : err_cnt;
    base_n    = mode_q ? words_n : elapsed_n;
    rem_n     = (target > base_n) ? target - base_n : '0;
    finish_n  = (base_n == target);
    wpm_num   = 16'(words_n) * 16'(60 * TICKS_PER_SEC);
    acc_num   = 16'(ok_cnt) * 16'd100;
    acc_den   = 16'(ok_cnt) + 16'(err_cnt);
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) cur <= T_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (ctrl == ST_SELECT) begin
      nxt = T_IDLE;
    end else begin
      case (cur)
        T_IDLE:     if (ctrl == ST_INGAME) nxt = finish_n ? T_CALC_WPM : T_RUN;
        T_RUN:      if (finish_n) nxt = T_CALC_WPM;
        T_CALC_WPM: if (div_done) nxt = T_CALC_ACC;
        T_CALC_ACC: if (div_done) nxt = T_DONE;
        default:    nxt = cur;
      endcase
    end
  end

  // The first INGAME tick already counts, so a race of N seconds ends on tick N*TICKS_PER_SEC.
  always_comb begin
    counting  = (ctrl != ST_SELECT) &&
                ((cur == T_RUN) || ((cur == T_IDLE) && (ctrl == ST_INGAME)));
    idle_hold = (cur == T_IDLE) && (ctrl != ST_INGAME);
    div_start = (counting && finish_n) ||
                ((cur == T_CALC_WPM) && div_done && (ctrl != ST_SELECT));
    div_a     = (cur == T_CALC_WPM) ? acc_num : wpm_num;
    div_b     = (cur == T_CALC_WPM) ? acc_den : 16'(ticks_n);
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      target <= '0;
      mode_q <= 1'b0;
    end else if (ctrl == ST_SELECT) begin
      target <= '0;
      mode_q <= 1'b0;
    end else if ((cur == T_IDLE) && (ctrl == ST_COUNTDOWN)) begin
      target <= value;
      mode_q <= mode;
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      ticks        <= '0;
      sub          <= '0;
      elapsed_s    <= '0;
      words        <= '0;
      ok_cnt       <= '0;
      err_cnt      <= '0;
      finish       <= 1'b0;
      remaining    <= '0;
      wpm          <= '0;
      accuracy     <= '0;
      result_valid <= 1'b0;
    end else if ((ctrl == ST_SELECT) || idle_hold) begin
      ticks        <= '0;
      sub          <= '0;
      elapsed_s    <= '0;
      words        <= '0;
      ok_cnt       <= '0;
      err_cnt      <= '0;
      finish       <= 1'b0;
      remaining    <= '0;
      wpm          <= '0;
      accuracy     <= '0;
      result_valid <= 1'b0;
    end else begin
      if (counting) begin
        ticks     <= ticks_n;
        sub       <= sub_n;
        elapsed_s <= elapsed_n;
        words     <= words_n;
        ok_cnt    <= ok_n;
        err_cnt   <= err_n;
        finish    <= finish_n;
        remaining <= finish_n ? '0 : rem_n;
      end
      if ((cur == T_CALC_WPM) && div_done)
        wpm <= (div_q > 16'(WPM_MAX)) ? 10'(WPM_MAX) : div_q[9:0];
      if ((cur == T_CALC_ACC) && div_done) begin
        accuracy     <= (acc_den == '0) ? 7'd100 : div_q[6:0];
        result_valid <= 1'b1;
      end
    end
  end

  seq_divider u_div (
    .clk_div  (clk_div),
    .rst      (rst),
    .clear    (ctrl == ST_SELECT),
    .start    (div_start),
    .dividend (div_a),
    .divisor  (div_b),
    .quotient (div_q),
    .remainder(),
    .busy     (div_busy),
    .done     (div_done)
  );

endmodule

// File: tb/tb_game_tracker.sv
// Directed-vector bench for game_tracker with hand-computed expectations.
module tb_game_tracker;

  logic       clk_div = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       mode;
  logic [6:0] value;
  logic       word_done, char_ok, char_err;
  logic       finish, result_valid;
  logic [6:0] remaining, elapsed_s, words, accuracy;
  logic [9:0] wpm;

  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;
  logic        rv_seen;

  always #5 clk_div = ~clk_div;

  game_tracker #(.TICKS_PER_SEC(10), .CNT_W(10)) dut (
    .clk_div     (clk_div),
    .rst         (rst),
    .state       (state),
    .mode        (mode),
    .value       (value),
    .word_done   (word_done),
    .char_ok     (char_ok),
    .char_err    (char_err),
    .finish      (finish),
    .remaining   (remaining),
    .elapsed_s   (elapsed_s),
    .words       (words),
    .wpm         (wpm),
    .accuracy    (accuracy),
    .result_valid(result_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk_div);
      #1;
    end
  endtask

  task automatic start_race(input logic m, input logic [6:0] v);
    state = 2'd1;
    mode  = m;
    value = v;
    tick(3);
    state = 2'd2;
  endtask

  initial begin
    rst = 1'b1; state = 2'd0; mode = 1'b0; value = '0;
    word_done = 1'b0; char_ok = 1'b0; char_err = 1'b0;
    tick(2);
    check("rst_finish", 32'(finish), 0);
    check("rst_words", 32'(words), 0);
    check("rst_wpm", 32'(wpm), 0);
    check("rst_acc", 32'(accuracy), 0);
    check("rst_valid", 32'(result_valid), 0);
    rst = 1'b0;
    tick(1);

    // Time race, 15 s, no keystrokes
    start_race(1'b0, 7'd15);
    tick(149);
    check("t15_finish_early", 32'(finish), 0);
    check("t15_elapsed_149", 32'(elapsed_s), 14);
    check("t15_remaining_149", 32'(remaining), 1);
    tick(1);
    check("t15_finish", 32'(finish), 1);
    check("t15_elapsed", 32'(elapsed_s), 15);
    check("t15_remaining", 32'(remaining), 0);
    state = 2'd3;
    tick(33);
    check("t15_valid_early", 32'(result_valid), 0);
    tick(1);
    check("t15_valid", 32'(result_valid), 1);
    check("t15_wpm", 32'(wpm), 0);
    check("t15_acc", 32'(accuracy), 100);
    check("t15_finish_held", 32'(finish), 1);
    state = 2'd0;
    tick(1);
    check("t15_finish_clr", 32'(finish), 0);

    // Word race, 25 words every 12 ticks, 90 ok / 10 err with two simultaneous
    start_race(1'b1, 7'd25);
    for (int t = 1; t <= 300; t++) begin
      word_done = (t % 12 == 0);
      char_ok   = (t <= 90);
      char_err  = (t >= 89) && (t <= 98);
      tick(1);
      if (t == 299) begin
        check("w25_finish_early", 32'(finish), 0);
        check("w25_words_299", 32'(words), 24);
        check("w25_remaining_299", 32'(remaining), 1);
      end
    end
    word_done = 1'b0; char_ok = 1'b0; char_err = 1'b0;
    check("w25_finish", 32'(finish), 1);
    check("w25_words", 32'(words), 25);
    check("w25_remaining", 32'(remaining), 0);
    check("w25_elapsed", 32'(elapsed_s), 30);
    state = 2'd3;
    word_done = 1'b1; char_err = 1'b1;
    tick(1);
    word_done = 1'b0; char_err = 1'b0;
    check("w25_late_pulse", 32'(words), 25);
    tick(32);
    check("w25_valid_early", 32'(result_valid), 0);
    tick(1);
    check("w25_valid", 32'(result_valid), 1);
    check("w25_wpm", 32'(wpm), 50);
    check("w25_acc", 32'(accuracy), 90);
    state = 2'd0;
    tick(1);

    // Abort during the WPM division
    start_race(1'b0, 7'd15);
    tick(150);
    check("abort_finish", 32'(finish), 1);
    state = 2'd3;
    tick(5);
    state = 2'd0;
    tick(1);
    check("abort_finish_clr", 32'(finish), 0);
    check("abort_elapsed", 32'(elapsed_s), 0);
    check("abort_wpm", 32'(wpm), 0);
    check("abort_valid", 32'(result_valid), 0);
    rv_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      rv_seen = rv_seen | result_valid;
    end
    check("abort_valid_never", 32'(rv_seen), 0);

    // Asynchronous reset mid-race
    start_race(1'b1, 7'd25);
    word_done = 1'b1;
    tick(10);
    word_done = 1'b0;
    check("rstmid_words", 32'(words), 10);
    check("rstmid_remaining", 32'(remaining), 15);
    #2;
    rst = 1'b1;
    state = 2'd0;
    #1;
    check("rstmid_words_async", 32'(words), 0);
    check("rstmid_elapsed_async", 32'(elapsed_s), 0);
    check("rstmid_remaining_async", 32'(remaining), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    start_race(1'b1, 7'd25);
    word_done = 1'b1;
    tick(1);
    word_done = 1'b0;
    check("rstmid_restart_words", 32'(words), 1);
    check("rstmid_restart_remaining", 32'(remaining), 24);
    state = 2'd0;
    tick(1);

    // Word counter saturation in a 90 s time race
    start_race(1'b0, 7'd90);
    word_done = 1'b1;
    tick(127);
    check("sat_words_127", 32'(words), 127);
    tick(3);
    word_done = 1'b0;
    check("sat_words_130", 32'(words), 127);
    check("sat_elapsed", 32'(elapsed_s), 13);
    check("sat_remaining", 32'(remaining), 77);
    check("sat_finish", 32'(finish), 0);
    state = 2'd0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/game_tracker.md
# game_tracker

Per-race measurement stage directly downstream of the game control FSM. Consumes its state, mode and selected target (`value`), counts elapsed time and typed words/characters during INGAME, and drives `finish` back to the control FSM. After the race it computes words-per-minute and accuracy with a shared sequential divider for the result display.

## Interface
Parameters:
- `TICKS_PER_SEC`, 10: clk_div ticks per second (clk_div = 10 Hz).
- `CNT_W`, 10: width of character counters.

Ports:
- `clk_div`  in  1  tick clock, 10 Hz.
- `rst`  in  1  asynchronous, active-high reset.
- `state`  in  2  control FSM state: 0 SELECT, 1 COUNTDOWN, 2 INGAME, 3 FINISH.
- `mode`  in  1  latched game mode: 0 time race, 1 word-count race.
- `value`  in  7  target: seconds (15..90) in time mode, words (25..100) in word mode.
- `word_done`  in  1  one-tick pulse per completed word; upstream stretches it to one clk_div period.
- `char_ok`  in  1  one-tick pulse per correct keystroke.
- `char_err`  in  1  one-tick pulse per wrong keystroke.
- `finish`  out  1  race complete; level.
- `remaining`  out  7  seconds or words left, for the HUD.
- `elapsed_s`  out  7  whole seconds elapsed in INGAME.
- `words`  out  7  completed words.
- `wpm`  out  10  result words per minute.
- `accuracy`  out  7  result percent correct, 0..100.
- `result_valid`  out  1  `wpm`/`accuracy` stable.

## Operation
- Internal FSM: IDLE, RUN, CALC_WPM, CALC_ACC, DONE.
- IDLE: while `state` is SELECT or COUNTDOWN, all counters, `finish`, `wpm`, `accuracy`, `result_valid` held at 0. In COUNTDOWN, `target` <= `value`, `mode_q` <= `mode` every tick (last value before INGAME wins).
- IDLE -> RUN when `state`==INGAME.
- RUN: `ticks` (12-bit, saturating 4095) +1 each tick; `sub` (0..TICKS_PER_SEC-1) wraps and increments `elapsed_s` (saturating 127). `word_done` increments `words` (sat 127). `char_ok`/`char_err` increment `ok_cnt`/`err_cnt` (sat 2^CNT_W-1). Simultaneous `char_ok` and `char_err` both count.
- Finish condition: mode_q=0 and `elapsed_s`==target, or mode_q=1 and `words`==target. `finish` set on the tick the condition becomes true in counter values (registered), RUN -> CALC_WPM same tick; counters freeze.
- Pulses arriving the tick `finish` rises are ignored.
- `remaining` = target - elapsed_s (mode_q=0) or target - words (mode_q=1), clamped at 0; 0 after finish.
- CALC_WPM: `wpm` = (words * 60 * TICKS_PER_SEC) / ticks, 16-bit unsigned, truncated, clamped to 999. ticks==0 -> 0.
- CALC_ACC: `accuracy` = (ok_cnt * 100) / (ok_cnt + err_cnt), truncated; denominator 0 -> 100.
- DONE: `result_valid`=1; outputs held.
- Any state -> IDLE when `state`==SELECT (clears everything, `finish`=0 next tick). `state` leaving INGAME to anything but FINISH/SELECT is impossible and ignored.
- `rst` at any time: immediate return to IDLE, all outputs 0.

## Timing
- All outputs registered on `clk_div`; reset value 0 for every output.
- Counter update latency: 1 tick after pulse.
- `finish` rises 1 tick after the final word pulse, or on the tick `elapsed_s` reaches target.
- Divider: 16 cycles per division plus 1 load cycle; `result_valid` rises 34 ticks after `finish` (≈3.4 s at 10 Hz).
- `finish` held high through FINISH until `state`==SELECT is sampled.

## Structure
- Shared package: state encodings (SELECT/COUNTDOWN/INGAME/FINISH), `TICKS_PER_SEC`, target limits (15..90 s, 25..100 words).
- One sub-module: `seq_divider` — 16/16 unsigned restoring divider, `start`/`busy`/`done` handshake, quotient + remainder, divide-by-zero -> quotient 0. Shared by both calculations; operand muxing in this block.

## Test plan
- Time mode, value=15, no pulses: finish rises after 150 INGAME ticks; elapsed_s=15, remaining=0, wpm=0, accuracy=100.
- Word mode, value=25, word_done every 12 ticks: finish 1 tick after 25th pulse; ticks=300, wpm=50.
- char_ok ×90, char_err ×10 (two simultaneous) -> accuracy=90 at result_valid, 34 ticks after finish.
- state -> SELECT during CALC_WPM: next tick all outputs 0, result_valid never asserts.
- rst pulse mid-RUN with words=10: outputs 0 asynchronously; next INGAME starts from words=0.
- Saturation: 130 word_done in time mode value=90 -> words holds 127, no wrap.
